// File: rtl/wb_timer_arbiter_if.sv
// Pipelined Wishbone link between one requester (master modport) and one
// completer (slave modport); used for both arbiter masters and the shared slave.
interface wb_timer_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            stall;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/wb_timer_arbiter.sv
// Two-master round-robin arbiter onto one pipelined Wishbone slave (wb_timer).
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_timer_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    wb_timer_arbiter_if.slave          m0,
    wb_timer_arbiter_if.slave          m1,
    wb_timer_arbiter_if.master         s,
    output logic [1:0]                 dbg_state_o,
    output logic [$clog2(TIMEOUT+2):0] dbg_outst_o
);

    localparam int OW = $clog2(TIMEOUT + 2) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [OW-1:0]   outst_q, outst_d;

    logic            gnt0;
    logic            gnt1;
    logic            granted;
    logic            active;
    logic            release_w;
    logic            abort_q;
    logic            expire;
    logic            fwd_ok;
    logic            inc;
    logic            dec;

    // Signals of the currently granted master
    logic            mc_cyc;
    logic            mc_stb;
    logic            mc_we;
    logic [AW-1:0]   mc_addr;
    logic [DW-1:0]   mc_dat;
    logic [DW/8-1:0] mc_sel;
    logic            other_cyc;

    // Response towards the granted master before routing
    logic            rsp_stall;
    logic            rsp_ack;
    logic            rsp_err;
    logic [DW-1:0]   rsp_dat;

    assign gnt0      = (state_q == G0);
    assign gnt1      = (state_q == G1);
    assign granted   = gnt0 | gnt1;

    always_comb begin
        mc_cyc    = 1'b0;
        mc_stb    = 1'b0;
        mc_we     = 1'b0;
        mc_addr   = '0;
        mc_dat    = '0;
        mc_sel    = '0;
        other_cyc = 1'b0;
        if (gnt0) begin
            mc_cyc    = m0.cyc;
            mc_stb    = m0.stb;
            mc_we     = m0.we;
            mc_addr   = m0.addr;
            mc_dat    = m0.dat_w;
            mc_sel    = m0.sel;
            other_cyc = m1.cyc;
        end else if (gnt1) begin
            mc_cyc    = m1.cyc;
            mc_stb    = m1.stb;
            mc_we     = m1.we;
            mc_addr   = m1.addr;
            mc_dat    = m1.dat_w;
            mc_sel    = m1.sel;
            other_cyc = m0.cyc;
        end
    end

    assign active    = granted & mc_cyc;
    assign release_w = granted & ~mc_cyc;

    // A beat transfers when stb is high and stall is low; every accepted beat
    // is answered by exactly one ack or err, in order.
    assign s.cyc   = active & ~abort_q;
    assign s.stb   = s.cyc & mc_stb;
    assign s.we    = mc_we;
    assign s.addr  = mc_addr;
    assign s.dat_w = mc_dat;
    assign s.sel   = mc_sel;

    // Responses only belong to the current master while it has beats pending
    assign fwd_ok    = (outst_q != '0);
    assign rsp_stall = ~granted | abort_q | s.stall;
    assign rsp_ack   = active & fwd_ok & s.ack;
    assign rsp_err   = active & ((fwd_ok & s.err) | expire);
    assign rsp_dat   = granted ? s.dat_r : '0;

    assign m0.stall = gnt0 ? rsp_stall : 1'b1;
    assign m0.ack   = gnt0 & rsp_ack;
    assign m0.err   = gnt0 & rsp_err;
    assign m0.dat_r = gnt0 ? rsp_dat : '0;

    assign m1.stall = gnt1 ? rsp_stall : 1'b1;
    assign m1.ack   = gnt1 & rsp_ack;
    assign m1.err   = gnt1 & rsp_err;
    assign m1.dat_r = gnt1 ? rsp_dat : '0;

    // Grant FSM: ties go to the master that did not win last time
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || last_q)) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (m1.cyc) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0, G1: begin
                if (!mc_cyc) begin
                    if (other_cyc) begin
                        state_d = gnt1 ? G0 : G1;
                        last_d  = ~gnt1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inc = s.stb & ~s.stall;
    assign dec = s.ack | s.err;

    always_comb begin
        outst_d = outst_q;
        if (release_w || expire) begin
            outst_d = '0;
        end else if (inc && !dec && (outst_q != '1)) begin
            outst_d = outst_q + OW'(1);
        end else if (dec && !inc && (outst_q != '0)) begin
            outst_d = outst_q - OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [OW-1:0] wd_q, wd_d;
    logic          abort_d;

    // Counts waiting cycles; the TIMEOUT-th one raises err and schedules a
    // one-cycle cyc drop so the slave forgets the hung beat.
    always_comb begin
        wd_d    = wd_q;
        expire  = 1'b0;
        abort_d = 1'b0;
        if ((outst_q == '0) || s.ack || s.err) begin
            wd_d = '0;
        end else if (wd_q == OW'(TIMEOUT - 1)) begin
            wd_d    = '0;
            expire  = active;
            abort_d = active;
        end else begin
            wd_d = wd_q + OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign abort_q = 1'b0;
`endif

    assign dbg_state_o = state_q;
    assign dbg_outst_o = outst_q;

endmodule

// File: tb/tb_wb_timer_arbiter.sv
// Directed bench for wb_timer_arbiter: reset, grant/handover, pipelined
// reads, late-ack dropping and (with WB_ARB_TIMEOUT_EN) the watchdog.
module tb_wb_timer_arbiter;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [1:0]                 dbg_state;
    logic [$clog2(TIMEOUT+2):0] dbg_outst;

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rd_vals [3];

    wb_timer_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    wb_timer_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    wb_timer_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    wb_timer_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .dbg_state_o (dbg_state),
        .dbg_outst_o (dbg_outst)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] dat);
        m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
        m0_if.addr = addr; m0_if.dat_w = dat; m0_if.sel = '1;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] dat);
        m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
        m1_if.addr = addr; m1_if.dat_w = dat; m1_if.sel = '1;
    endtask

    task automatic drive_slv(input logic stall, input logic ack, input logic err,
                             input logic [DW-1:0] dat);
        s_if.stall = stall; s_if.ack = ack; s_if.err = err; s_if.dat_r = dat;
    endtask

    initial begin
        rd_vals[0] = 32'hA;
        rd_vals[1] = 32'hB;
        rd_vals[2] = 32'hC;
        rst_n = 1'b0;
        drive_m0(0, 0, 0, 0, 0);
        drive_m1(0, 0, 0, 0, 0);
        drive_slv(0, 0, 0, 0);

        // reset values
        step();
        @(negedge clk);
        check("rst_state", dbg_state, 0);
        check("rst_outst", dbg_outst, 0);
        check("rst_s_cyc", s_if.cyc, 0);
        check("rst_s_stb", s_if.stb, 0);
        check("rst_m0_stall", m0_if.stall, 1);
        check("rst_m1_stall", m1_if.stall, 1);
        check("rst_m0_ack", m0_if.ack, 0);
        check("rst_m0_dat", m0_if.dat_r, 0);
        step();
        rst_n = 1'b1;

        // tie after reset, direct handover, second tie
        step();
        drive_m0(1, 0, 0, 0, 0);
        drive_m1(1, 0, 0, 0, 0);
        @(negedge clk);
        check("tie_latency_state", dbg_state, 0);
        check("tie_latency_scyc", s_if.cyc, 0);
        step();
        @(negedge clk);
        check("tie1_state", dbg_state, 1);
        check("tie1_s_cyc", s_if.cyc, 1);
        check("tie1_m1_stall", m1_if.stall, 1);
        step();
        drive_m0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rel0_s_cyc", s_if.cyc, 0);
        step();
        @(negedge clk);
        check("handover_state", dbg_state, 2);
        check("handover_s_cyc", s_if.cyc, 1);
        check("handover_m0_stall", m0_if.stall, 1);
        step();
        drive_m1(0, 0, 0, 0, 0);
        step();
        drive_m0(1, 0, 0, 0, 0);
        drive_m1(1, 0, 0, 0, 0);
        @(negedge clk);
        check("idle_after_m1", dbg_state, 0);
        step();
        @(negedge clk);
        check("tie2_state", dbg_state, 1);
        step();
        drive_m0(0, 0, 0, 0, 0);
        drive_m1(0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("tie2_idle", dbg_state, 0);

        // m0 single write
        step();
        drive_m0(1, 1, 1, 8'h02, 32'h1234_5678);
        @(negedge clk);
        check("wr_latency_state", dbg_state, 0);
        check("wr_latency_stall", m0_if.stall, 1);
        step();
        @(negedge clk);
        check("wr_state", dbg_state, 1);
        check("wr_s_cyc", s_if.cyc, 1);
        check("wr_s_stb", s_if.stb, 1);
        check("wr_s_we", s_if.we, 1);
        check("wr_s_addr", s_if.addr, 8'h02);
        check("wr_s_dat", s_if.dat_w, 32'h1234_5678);
        check("wr_s_sel", s_if.sel, 4'hF);
        check("wr_m0_stall", m0_if.stall, 0);
        check("wr_m1_stall", m1_if.stall, 1);
        step();
        drive_m0(1, 0, 1, 8'h02, 32'h1234_5678);
        drive_slv(0, 1, 0, 0);
        @(negedge clk);
        check("wr_outst", dbg_outst, 1);
        check("wr_m0_ack", m0_if.ack, 1);
        check("wr_m1_ack", m1_if.ack, 0);
        step();
        drive_slv(0, 0, 0, 0);
        drive_m0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("wr_outst_done", dbg_outst, 0);
        check("wr_rel_s_cyc", s_if.cyc, 0);
        step();
        @(negedge clk);
        check("wr_idle", dbg_state, 0);

        // m0 three pipelined reads
        for (int i = 0; i < 3; i++) exp_q.push_back(rd_vals[i]);
        step();
        drive_m0(1, 1, 0, 8'h00, 0);
        step();
        @(negedge clk);
        check("rd_s_stb", s_if.stb, 1);
        step();
        drive_m0(1, 1, 0, 8'h01, 0);
        @(negedge clk);
        check("rd_outst1", dbg_outst, 1);
        step();
        drive_m0(1, 1, 0, 8'h02, 0);
        @(negedge clk);
        check("rd_outst2", dbg_outst, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) drive_m0(1, 0, 0, 8'h02, 0);
            drive_slv(0, 1, 0, rd_vals[i]);
            @(negedge clk);
            check("rd_outst_pend", dbg_outst, 64'(3 - i));
            check("rd_m0_ack", m0_if.ack, 1);
            if (m0_if.ack && exp_q.size() > 0) check("rd_m0_data", m0_if.dat_r, exp_q.pop_front());
        end
        step();
        drive_slv(0, 0, 0, 0);
        @(negedge clk);
        check("rd_outst_zero", dbg_outst, 0);
        check("rd_ack_end", m0_if.ack, 0);
        check("rd_sb_empty", 64'(exp_q.size()), 0);
        drive_m0(0, 0, 0, 0, 0);
        step();
        step();

        // m1 releases with one beat pending; late ack is dropped
        drive_m1(1, 1, 1, 8'h05, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        check("late_state_g1", dbg_state, 2);
        step();
        drive_m1(0, 0, 0, 0, 0);
        drive_m0(1, 0, 0, 0, 0);
        @(negedge clk);
        check("late_outst_pend", dbg_outst, 1);
        check("late_rel_s_cyc", s_if.cyc, 0);
        step();
        drive_slv(0, 1, 0, 32'h5555_5555);
        @(negedge clk);
        check("late_state_g0", dbg_state, 1);
        check("late_m0_ack", m0_if.ack, 0);
        check("late_m1_ack", m1_if.ack, 0);
        check("late_outst", dbg_outst, 0);
        step();
        drive_slv(0, 0, 0, 0);
        @(negedge clk);
        check("late_outst_after", dbg_outst, 0);
        step();
        drive_m0(0, 0, 0, 0, 0);
        step();

        // hung slave: one read never answered
        drive_m0(1, 1, 0, 8'h03, 0);
        step();
        @(negedge clk);
        check("hang_s_stb", s_if.stb, 1);
        step();
        drive_m0(1, 0, 0, 8'h03, 0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
            check("wd_m0_err", m0_if.err, (k == 4) ? 1 : 0);
            if (k == 5) begin
                check("wd_abort_s_cyc", s_if.cyc, 0);
                check("wd_abort_stall", m0_if.stall, 1);
                check("wd_outst_clr", dbg_outst, 0);
            end
            if (k == 6) check("wd_resume_s_cyc", s_if.cyc, 1);
`else
            check("hang_m0_err", m0_if.err, 0);
            check("hang_s_cyc", s_if.cyc, 1);
            check("hang_outst", dbg_outst, 1);
`endif
        end
        step();
        drive_m0(0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        check("hang_rel_outst", dbg_outst, 0);
        check("hang_rel_state", dbg_state, 0);

        // reset in the middle of a burst
        step();
        drive_m0(1, 1, 1, 8'h07, 32'h0BAD_F00D);
        step();
        @(negedge clk);
        check("mid_state_g0", dbg_state, 1);
        drive_slv(0, 1, 0, 32'hFFFF_FFFF);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_s_cyc", s_if.cyc, 0);
        check("mid_rst_m0_stall", m0_if.stall, 1);
        check("mid_rst_m1_stall", m1_if.stall, 1);
        check("mid_rst_m0_ack", m0_if.ack, 0);
        check("mid_rst_m0_dat", m0_if.dat_r, 0);
        check("mid_rst_outst", dbg_outst, 0);
        step();
        rst_n = 1'b1;
        drive_m0(0, 0, 0, 0, 0);
        drive_slv(0, 0, 0, 0);
        step();
        @(negedge clk);
        check("post_rst_state", dbg_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
